// File: rtl/if_stage_ctrl.sv
// Instruction-fetch stage controller: owns the PC and the IF/ID register,
// freezes on load-use stalls, buffers late instructions and flushes on taken branches.
module if_stage_ctrl #(
  parameter logic [31:0] ResetPC    = 32'h0000_0000,
  parameter int unsigned CountWidth = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  PCWrite,
  input  logic                  IFIDWrite,
  input  logic                  BranchTaken,
  input  logic [31:0]           BranchTarget,
  output logic                  IMemReq,
  output logic [31:0]           IMemAddr,
  input  logic                  IMemReady,
  input  logic [31:0]           IMemData,
  output logic [31:0]           IFIDInstr,
  output logic [31:0]           IFIDPCPlus4,
  output logic                  IFIDValid,
  output logic [CountWidth-1:0] StallCount
);

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Fetch = 2'd1,
    Hold  = 2'd2
  } stateT;

  stateT       state;
  stateT       stateNext;
  logic [31:0] pcReg;
  logic [31:0] pcPlus4;
  logic [31:0] holdBuf;

  logic [31:0] pcNext;
  logic [31:0] holdBufNext;
  logic [31:0] instrNext;
  logic [31:0] pcPlus4Next;
  logic        validNext;

  assign pcPlus4  = pcReg + 32'd4;
  assign IMemAddr = pcReg;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= Idle;
    else       state <= stateNext;
  end

  // Next-state logic; a taken branch always lands in Fetch
  always_comb begin
    stateNext = state;
    if (BranchTaken) begin
      stateNext = Fetch;
    end else begin
      case (state)
        Idle:    stateNext = Fetch;
        Fetch:   if (IMemReady && !IFIDWrite) stateNext = Hold;
        Hold:    if (IFIDWrite) stateNext = Fetch;
        default: stateNext = Idle;
      endcase
    end
  end

  // Output logic: request only while fetching
  always_comb begin
    IMemReq = 1'b0;
    if (state == Fetch) IMemReq = 1'b1;
  end

  // Datapath next values for PC, hold buffer and IF/ID
  always_comb begin
    pcNext      = pcReg;
    holdBufNext = holdBuf;
    instrNext   = IFIDInstr;
    pcPlus4Next = IFIDPCPlus4;
    validNext   = IFIDValid;
    if (BranchTaken) begin
      pcNext      = BranchTarget;
      holdBufNext = 32'h0;
      instrNext   = 32'h0;
      validNext   = 1'b0;
    end else begin
      case (state)
        Fetch: begin
          if (IMemReady && IFIDWrite) begin
            instrNext   = IMemData;
            pcPlus4Next = pcPlus4;
            validNext   = 1'b1;
            if (PCWrite) pcNext = pcPlus4;
          end else if (IMemReady) begin
            holdBufNext = IMemData;
          end else if (IFIDWrite) begin
            instrNext = 32'h0;
            validNext = 1'b0;
          end
        end
        Hold: begin
          if (IFIDWrite) begin
            instrNext   = holdBuf;
            pcPlus4Next = pcPlus4;
            validNext   = 1'b1;
            holdBufNext = 32'h0;
            if (PCWrite) pcNext = pcPlus4;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pcReg       <= ResetPC;
      holdBuf     <= 32'h0;
      IFIDInstr   <= 32'h0;
      IFIDPCPlus4 <= 32'h0;
      IFIDValid   <= 1'b0;
    end else begin
      pcReg       <= pcNext;
      holdBuf     <= holdBufNext;
      IFIDInstr   <= instrNext;
      IFIDPCPlus4 <= pcPlus4Next;
      IFIDValid   <= validNext;
    end
  end

  // Saturating count of cycles with IF/ID frozen
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCount <= '0;
    end else if (!IFIDWrite && (StallCount != '1)) begin
      StallCount <= StallCount + CountWidth'(1);
    end
  end

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl: streaming, load-use hold, memory wait,
// branch flush from Hold, PC wrap and mid-operation reset.
module tb_if_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        IMemReady;
  logic [31:0] IMemData;

  logic        IMemReq,     wIMemReq;
  logic [31:0] IMemAddr,    wIMemAddr;
  logic [31:0] IFIDInstr,   wIFIDInstr;
  logic [31:0] IFIDPCPlus4, wIFIDPCPlus4;
  logic        IFIDValid,   wIFIDValid;
  logic [15:0] StallCount,  wStallCount;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  if_stage_ctrl #(.ResetPC(32'h0000_0000), .CountWidth(16)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady), .IMemData(IMemData),
    .IFIDInstr(IFIDInstr), .IFIDPCPlus4(IFIDPCPlus4), .IFIDValid(IFIDValid),
    .StallCount(StallCount)
  );

  if_stage_ctrl #(.ResetPC(32'hFFFF_FFFC), .CountWidth(16)) dutWrap (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .IMemReq(wIMemReq), .IMemAddr(wIMemAddr), .IMemReady(IMemReady), .IMemData(IMemData),
    .IFIDInstr(wIFIDInstr), .IFIDPCPlus4(wIFIDPCPlus4), .IFIDValid(wIFIDValid),
    .StallCount(wStallCount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkIfid(input string tag, input logic [31:0] instr,
                           input logic [31:0] pcp4, input logic valid);
    check({tag, "_instr"}, IFIDInstr, instr);
    check({tag, "_pcp4"}, IFIDPCPlus4, pcp4);
    check({tag, "_valid"}, 32'(IFIDValid), 32'(valid));
  endtask

  initial begin
    reset = 1'b1; PCWrite = 1'b1; IFIDWrite = 1'b1; BranchTaken = 1'b0;
    BranchTarget = 32'h0; IMemReady = 1'b0; IMemData = 32'h0;
    tick(); tick();
    check("rst_req", 32'(IMemReq), 32'd0);
    check("rst_addr", IMemAddr, 32'h0);
    checkIfid("rst", 32'h0, 32'h0, 1'b0);
    check("rst_stall", 32'(StallCount), 32'd0);
    check("rst_wrap_addr", wIMemAddr, 32'hFFFF_FFFC);

    // Release reset: first cycle is Idle, request rises on the second
    reset = 1'b0; IMemReady = 1'b1; IMemData = 32'h2008_0001;
    check("idle_req", 32'(IMemReq), 32'd0);
    tick();
    check("fetch_req", 32'(IMemReq), 32'd1);
    check("fetch_addr0", IMemAddr, 32'h0);
    tick();
    checkIfid("s1", 32'h2008_0001, 32'h4, 1'b1);
    check("s1_addr", IMemAddr, 32'h4);
    check("wrap_pcp4", wIFIDPCPlus4, 32'h0);
    check("wrap_addr", wIMemAddr, 32'h0);
    IMemData = 32'h2009_0002;
    tick();
    checkIfid("s2", 32'h2009_0002, 32'h8, 1'b1);
    check("s2_stall", 32'(StallCount), 32'd0);

    // Load-use stall while PC=8 data returns
    PCWrite = 1'b0; IFIDWrite = 1'b0; IMemData = 32'h200A_0003;
    tick();
    checkIfid("hold", 32'h2009_0002, 32'h8, 1'b1);
    check("hold_req", 32'(IMemReq), 32'd0);
    check("hold_addr", IMemAddr, 32'h8);
    check("hold_stall", 32'(StallCount), 32'd1);
    PCWrite = 1'b1; IFIDWrite = 1'b1; IMemData = 32'hDEAD_BEEF;
    tick();
    checkIfid("unhold", 32'h200A_0003, 32'hC, 1'b1);
    check("unhold_req", 32'(IMemReq), 32'd1);
    check("unhold_addr", IMemAddr, 32'hC);
    check("unhold_stall", 32'(StallCount), 32'd1);

    // Memory not ready for three cycles: bubbles, PC held
    IMemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkIfid($sformatf("wait%0d", i), 32'h0, 32'hC, 1'b0);
      check($sformatf("wait%0d_addr", i), IMemAddr, 32'hC);
    end
    IMemReady = 1'b1; IMemData = 32'h200B_0004;
    tick();
    checkIfid("resume", 32'h200B_0004, 32'h10, 1'b1);
    check("resume_addr", IMemAddr, 32'h10);

    // PCWrite=0 with IFIDWrite=1: IF/ID loads, PC refetches same address
    PCWrite = 1'b0; IMemData = 32'h200C_0005;
    tick();
    checkIfid("refetch", 32'h200C_0005, 32'h14, 1'b1);
    check("refetch_addr", IMemAddr, 32'h10);

    // Stall into Hold with a buffered instruction, then branch out of it
    IFIDWrite = 1'b0; IMemData = 32'h1111_1111;
    tick();
    check("hold2_req", 32'(IMemReq), 32'd0);
    check("hold2_stall", 32'(StallCount), 32'd2);
    BranchTaken = 1'b1; BranchTarget = 32'h40; IMemData = 32'h2222_2222;
    tick();
    checkIfid("flush", 32'h0, 32'h14, 1'b0);
    check("flush_addr", IMemAddr, 32'h40);
    check("flush_req", 32'(IMemReq), 32'd1);
    check("flush_stall", 32'(StallCount), 32'd3);
    BranchTaken = 1'b0; PCWrite = 1'b1; IFIDWrite = 1'b1; IMemData = 32'h3333_3333;
    tick();
    checkIfid("target", 32'h3333_3333, 32'h44, 1'b1);
    check("target_addr", IMemAddr, 32'h44);

    // Reset asserted while in Hold overrides everything
    PCWrite = 1'b0; IFIDWrite = 1'b0; IMemData = 32'h4444_4444;
    tick();
    check("hold3_req", 32'(IMemReq), 32'd0);
    check("hold3_stall", 32'(StallCount), 32'd4);
    reset = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h80;
    tick();
    checkIfid("rst2", 32'h0, 32'h0, 1'b0);
    check("rst2_stall", 32'(StallCount), 32'd0);
    check("rst2_addr", IMemAddr, 32'h0);
    check("rst2_req", 32'(IMemReq), 32'd0);
    reset = 1'b0; BranchTaken = 1'b0; PCWrite = 1'b1; IFIDWrite = 1'b1;
    IMemData = 32'h5555_5555;
    tick();
    check("rst2_fetch_req", 32'(IMemReq), 32'd1);
    tick();
    checkIfid("post_rst", 32'h5555_5555, 32'h4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
